// File: rtl/lz77_frame_ctrl.sv
// rtl/lz77_frame_ctrl.sv - LZ77 encoder frame sequencer: char loading, token FIFO, re-arm.
// Optional watchdog on stalled encodes: define LZ77_FRAME_CTRL_TIMEOUT_EN.
module lz77_frame_ctrl #(
    parameter int FRAME_LEN  = 2048,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4095
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        enc_reset,
    output logic [7:0]  enc_chardata,
    input  logic        enc_valid,
    input  logic [3:0]  enc_offset,
    input  logic [2:0]  enc_match_len,
    input  logic [7:0]  enc_char_nxt,
    input  logic        enc_finish,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [14:0] m_token,
    output logic        m_last,
    output logic        busy,
    output logic [7:0]  frame_cnt,
    output logic        err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, ENCODE, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [10:0]   load_cnt_q, load_cnt_d;
    logic [14:0]   mem_q [FIFO_DEPTH];
    logic [14:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          err_q, err_d;
    logic          err_frame_q, err_frame_d;
    logic          push_req, pop, full, do_push, err_set;
`ifdef LZ77_FRAME_CTRL_TIMEOUT_EN
    logic [11:0]   wd_q, wd_d;
`endif

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        err_frame_d = err_frame_q;
`ifdef LZ77_FRAME_CTRL_TIMEOUT_EN
        wd_d        = wd_q;
`endif

        push_req = (state_q == ENCODE) && enc_valid;
        pop      = (cnt_q != '0) && m_ready;
        full     = (cnt_q == CW'(FIFO_DEPTH));
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        do_push  = push_req && (!full || pop);
        err_set  = push_req && full && !pop;

        if (do_push) begin
            mem_d[wr_ptr_q] = {enc_offset, enc_match_len, enc_char_nxt};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!do_push && pop) begin
            cnt_d = cnt_q - CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    state_d     = LOAD;
                    load_cnt_d  = '0;
                    err_frame_d = 1'b0;
                end
            end
            LOAD: begin
                // The encoder loads one char every cycle and cannot stall.
                if (!s_valid) begin
                    err_set = 1'b1;
                    state_d = DRAIN;
                end else begin
                    load_cnt_d = load_cnt_q + 11'd1;
                    if (load_cnt_q == 11'(FRAME_LEN - 1)) begin
                        state_d = ENCODE;
`ifdef LZ77_FRAME_CTRL_TIMEOUT_EN
                        wd_d    = '0;
`endif
                    end
                end
            end
            ENCODE: begin
                if (enc_finish) begin
                    state_d = DRAIN;
                end
`ifdef LZ77_FRAME_CTRL_TIMEOUT_EN
                wd_d = enc_valid ? 12'd0 : wd_q + 12'd1;
                if (wd_q == 12'(TIMEOUT - 1)) begin
                    err_set = 1'b1;
                    state_d = DRAIN;
                end
`endif
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    if (!err_frame_q) begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_set) begin
            err_d       = 1'b1;
            err_frame_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            load_cnt_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
            err_frame_q <= 1'b0;
`ifdef LZ77_FRAME_CTRL_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            err_frame_q <= err_frame_d;
`ifdef LZ77_FRAME_CTRL_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign s_ready      = (state_q == LOAD);
    assign enc_reset    = !reset_n || (state_q == IDLE) || (state_q == DRAIN);
    assign enc_chardata = s_ready ? s_data : 8'h00;
    assign m_valid      = (cnt_q != '0);
    assign m_token      = mem_q[rd_ptr_q];
    assign m_last       = (m_token[7:0] == 8'h24);
    assign busy         = (state_q != IDLE);
    assign frame_cnt    = frame_cnt_q;
    assign err          = err_q;
endmodule

// File: tb/tb_lz77_frame_ctrl.sv
// tb/tb_lz77_frame_ctrl.sv - directed self-checking bench for lz77_frame_ctrl.
module tb_lz77_frame_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        enc_reset;
    logic [7:0]  enc_chardata;
    logic        enc_valid = 1'b0;
    logic [3:0]  enc_offset = 4'h0;
    logic [2:0]  enc_match_len = 3'h0;
    logic [7:0]  enc_char_nxt = 8'h00;
    logic        enc_finish = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [14:0] m_token;
    logic        m_last;
    logic        busy;
    logic [7:0]  frame_cnt;
    logic        err;

    int n_cmp = 0;
    int n_fail = 0;

    lz77_frame_ctrl #(.FRAME_LEN(2048), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .enc_reset(enc_reset), .enc_chardata(enc_chardata),
        .enc_valid(enc_valid), .enc_offset(enc_offset), .enc_match_len(enc_match_len),
        .enc_char_nxt(enc_char_nxt), .enc_finish(enc_finish), .m_valid(m_valid),
        .m_ready(m_ready), .m_token(m_token), .m_last(m_last), .busy(busy),
        .frame_cnt(frame_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [14:0] tok(input int i);
        return {4'(i + 1), 3'(i % 8), 8'(65 + i)};
    endfunction

    task automatic drive_tok(input logic [14:0] t);
        {enc_offset, enc_match_len, enc_char_nxt} = t;
        enc_valid = 1'b1;
    endtask

    // Streams '0'..'9' repeating; drops s_valid when drop_at handshakes are done.
    task automatic load_frame(input int drop_at, output int hs);
        int  cyc;
        logic seen;
        hs = 0;
        seen = 1'b0;
        s_valid = 1'b1;
        for (cyc = 0; cyc < 2200; cyc++) begin
            s_data = 8'(48 + hs % 10);
            if (hs == drop_at) s_valid = 1'b0;
            #1;
            if (s_ready) begin
                seen = 1'b1;
                if (s_valid) hs++;
                if (hs == 4 && s_valid) chk("enc_chardata", 32'(enc_chardata), 32'h33);
            end
            tick();
            if (seen && !s_ready) break;
        end
        s_valid = 1'b0;
        chk("load_bound", 32'(cyc < 2200), 32'd1);
    endtask

    initial begin
        logic [14:0] t;
        int hs;

        #1;
        chk("rst_enc_reset", 32'(enc_reset), 32'd1);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_token", 32'(m_token), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_chardata", 32'(enc_chardata), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Reset asserted mid-LOAD at load_cnt=100
        s_valid = 1'b1;
        s_data = 8'h31;
        tick();
        repeat (100) tick();
        chk("midload_s_ready", 32'(s_ready), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_enc_reset", 32'(enc_reset), 32'd1);
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        s_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // Clean frame, tokens streamed out with m_ready=1
        load_frame(-1, hs);
        chk("f1_handshakes", 32'(hs), 32'd2048);
        chk("f1_enc_reset", 32'(enc_reset), 32'd0);
        chk("f1_busy", 32'(busy), 32'd1);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            t = tok(i);
            if (i == 4) t[7:0] = 8'h24;
            drive_tok(t);
            enc_finish = (i == 4);
            tick();
            enc_valid = 1'b0;
            enc_finish = 1'b0;
            chk("f1_m_valid", 32'(m_valid), 32'd1);
            chk("f1_m_token", 32'(m_token), 32'(t));
            chk("f1_m_last", 32'(m_last), 32'(i == 4));
            tick();
        end
        tick();
        chk("f1_busy_end", 32'(busy), 32'd0);
        chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("f1_err", 32'(err), 32'd0);
        chk("f1_m_valid_end", 32'(m_valid), 32'd0);

        // Full FIFO with coincident push and pop
        load_frame(-1, hs);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_tok(tok(i));
            tick();
            enc_valid = 1'b0;
            tick();
        end
        chk("f2_head", 32'(m_token), 32'(tok(0)));
        chk("f2_err_full", 32'(err), 32'd0);
        drive_tok(tok(4));
        m_ready = 1'b1;
        tick();
        enc_valid = 1'b0;
        m_ready = 1'b0;
        chk("f2_err_coinc", 32'(err), 32'd0);
        chk("f2_head_coinc", 32'(m_token), 32'(tok(1)));
        enc_finish = 1'b1;
        tick();
        enc_finish = 1'b0;
        m_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            #1;
            chk("f2_drain_valid", 32'(m_valid), 32'd1);
            chk("f2_drain_token", 32'(m_token), 32'(tok(i)));
            tick();
        end
        chk("f2_empty", 32'(m_valid), 32'd0);
        tick();
        chk("f2_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("f2_err", 32'(err), 32'd0);
        chk("f2_busy", 32'(busy), 32'd0);

        // Overflow: fifth token dropped while m_ready=0
        load_frame(-1, hs);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_tok(tok(i));
            tick();
            enc_valid = 1'b0;
            if (i == 3) chk("f3_err_before", 32'(err), 32'd0);
            tick();
        end
        chk("f3_err_overflow", 32'(err), 32'd1);
        enc_finish = 1'b1;
        tick();
        enc_finish = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("f3_drain_valid", 32'(m_valid), 32'd1);
            chk("f3_drain_token", 32'(m_token), 32'(tok(i)));
            tick();
        end
        chk("f3_empty", 32'(m_valid), 32'd0);
        tick();
        chk("f3_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("f3_busy", 32'(busy), 32'd0);

        // Token strobe outside ENCODE is ignored
        m_ready = 1'b0;
        drive_tok(tok(7));
        tick();
        enc_valid = 1'b0;
        chk("idle_strobe_ignored", 32'(m_valid), 32'd0);

        // Underrun at load_cnt=500
        load_frame(500, hs);
        chk("ur_handshakes", 32'(hs), 32'd500);
        chk("ur_enc_reset", 32'(enc_reset), 32'd1);
        chk("ur_s_ready", 32'(s_ready), 32'd0);
        chk("ur_err", 32'(err), 32'd1);
        tick();
        chk("ur_busy", 32'(busy), 32'd0);
        chk("ur_frame_cnt", 32'(frame_cnt), 32'd2);

        // Clean frame after errors: counts, err stays sticky
        load_frame(-1, hs);
        chk("f4_handshakes", 32'(hs), 32'd2048);
        drive_tok({4'd0, 3'd0, 8'h24});
        enc_finish = 1'b1;
        tick();
        enc_valid = 1'b0;
        enc_finish = 1'b0;
        m_ready = 1'b1;
        chk("f4_m_last", 32'(m_last), 32'd1);
        tick();
        tick();
        chk("f4_frame_cnt", 32'(frame_cnt), 32'd3);
        chk("f4_err_sticky", 32'(err), 32'd1);
        chk("f4_busy", 32'(busy), 32'd0);

`ifdef LZ77_FRAME_CTRL_TIMEOUT_EN
        load_frame(-1, hs);
        repeat (15) tick();
        chk("wd_before", 32'(enc_reset), 32'd0);
        tick();
        chk("wd_fired", 32'(enc_reset), 32'd1);
        tick();
        chk("wd_idle", 32'(busy), 32'd0);
        chk("wd_frame_cnt", 32'(frame_cnt), 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
